// File: rtl/sinc3_dec.sv
// sinc3_dec: third-order CIC (sinc3) decimator for a 1-bit sigma-delta bitstream.
// Optional macro SINC3_OVR_EN adds the full-scale flag output ovr.
module sinc3_dec #(
  parameter int OSR   = 256,
  parameter int OUT_W = 3 * $clog2(OSR) + 1
) (
  input  logic             mclkin,
  input  logic             rst,
  input  logic             mdat,
  input  logic             en,
  output logic [OUT_W-1:0] data_out,
`ifdef SINC3_OVR_EN
  output logic             ovr,
`endif
  output logic             data_valid
);

  localparam int CNT_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  logic [OUT_W-1:0] i1_reg, i2_reg, i3_reg;
  logic [OUT_W-1:0] x_reg;
  logic [OUT_W-1:0] d1_reg, d2_reg, d3_reg;
  logic [OUT_W-1:0] c1, c2, c3;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       settle_reg;
  logic             comb_stb_reg;
  logic             dec_edge;
  logic             settled;

  assign dec_edge = en && (cnt_reg == CNT_LAST);
  assign settled  = (settle_reg == 2'd2);

  // Integrators run at the modulator rate; wrap-around is cancelled by the combs.
  always_ff @(posedge mclkin or posedge rst) begin
    if (rst) begin
      i1_reg <= '0;
      i2_reg <= '0;
      i3_reg <= '0;
    end else if (en) begin
      i1_reg <= i1_reg + {{(OUT_W-1){1'b0}}, mdat};
      i2_reg <= i2_reg + i1_reg;
      i3_reg <= i3_reg + i2_reg;
    end
  end

  always_ff @(posedge mclkin or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      x_reg        <= '0;
      comb_stb_reg <= 1'b0;
    end else begin
      comb_stb_reg <= dec_edge;
      if (en) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (dec_edge) begin
        x_reg <= i3_reg;
      end
    end
  end

  always_comb begin
    c1 = x_reg - d1_reg;
    c2 = c1 - d2_reg;
    c3 = c2 - d3_reg;
  end

  // Comb step runs on the cycle after the decimation edge, independent of en.
  always_ff @(posedge mclkin or posedge rst) begin
    if (rst) begin
      d1_reg     <= '0;
      d2_reg     <= '0;
      d3_reg     <= '0;
      settle_reg <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (comb_stb_reg) begin
        d1_reg <= x_reg;
        d2_reg <= c1;
        d3_reg <= c2;
        if (settled) begin
          data_out   <= c3;
          data_valid <= 1'b1;
        end else begin
          settle_reg <= settle_reg + 2'd1;
        end
      end
    end
  end

`ifdef SINC3_OVR_EN
  localparam logic [OUT_W-1:0] FULL_SCALE = OUT_W'(OSR * OSR * OSR);

  always_ff @(posedge mclkin or posedge rst) begin
    if (rst) begin
      ovr <= 1'b0;
    end else begin
      ovr <= comb_stb_reg && settled && (c3 == FULL_SCALE);
    end
  end
`else
  // No full-scale flag in this build.
`endif

endmodule

// File: tb/tb_sinc3_dec.sv
// tb_sinc3_dec: directed tests of sinc3_dec at OSR=4 and OSR=256 with hand-computed results.
module tb_sinc3_dec;

  localparam int OSR_S = 4;
  localparam int W_S   = 7;
  localparam int OSR_B = 256;
  localparam int W_B   = 25;
  localparam logic [W_B-1:0] FULL_B = 25'd16777216;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, mdat, en;
  logic [W_S-1:0] data_out;
  logic           data_valid;
  logic           rst_b, mdat_b, en_b;
  logic [W_B-1:0] data_out_b;
  logic           data_valid_b;
`ifdef SINC3_OVR_EN
  logic           ovr, ovr_b;
`endif

  sinc3_dec #(.OSR(OSR_S), .OUT_W(W_S)) u_dut (
    .mclkin     (clk),
    .rst        (rst),
    .mdat       (mdat),
    .en         (en),
    .data_out   (data_out),
`ifdef SINC3_OVR_EN
    .ovr        (ovr),
`endif
    .data_valid (data_valid)
  );

  sinc3_dec #(.OSR(OSR_B), .OUT_W(W_B)) u_big (
    .mclkin     (clk),
    .rst        (rst_b),
    .mdat       (mdat_b),
    .en         (en_b),
    .data_out   (data_out_b),
`ifdef SINC3_OVR_EN
    .ovr        (ovr_b),
`endif
    .data_valid (data_valid_b)
  );

  int errors = 0;
  int checks = 0;
  int en_mode = 0;  // 0: en always 1, 1: en toggles 1,0,...
  int md_mode = 1;  // 0: mdat 0, 1: mdat 1, 2: mdat alternates 1,0,...
  bit phase = 1'b1;

  // Advance to the next falling edge and set inputs for the following rising edge.
  task automatic tick();
    @(negedge clk);
    phase = ~phase;
    en    = (en_mode == 1) ? phase : 1'b1;
    mdat  = (md_mode == 2) ? phase : (md_mode == 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    phase = 1'b1;
    en    = 1'b1;
    mdat  = (md_mode == 2) ? 1'b1 : (md_mode == 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns the number of ticks until data_valid is seen, or -1 if none within budget.
  task automatic wait_strobe(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (data_valid === 1'b1) begin
        n = k;
        $display("strobe: after %0d cycles data_out=%0d", k, data_out);
        break;
      end
    end
  endtask

  task automatic wait_strobe_b(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (data_valid_b === 1'b1) begin
        n = k;
        $display("strobe osr256: after %0d cycles data_out=%0d", k, data_out_b);
        break;
      end
    end
  endtask

  task automatic test_reset();
    en_mode = 0; md_mode = 1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 7'd0) begin
      errors++; $display("FAIL reset_data_out: got %0d expected 0", data_out);
    end
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_scale();
    int n;
    en_mode = 0; md_mode = 1;
    do_reset();
    wait_strobe(40, n);
    checks++;
    if (n !== 13) begin
      errors++; $display("FAIL fs_first_latency: got %0d cycles expected 13", n);
    end
    checks++;
    if (data_out !== 7'd63) begin
      errors++; $display("FAIL fs_first_value: got %0d expected 63", data_out);
    end
`ifdef SINC3_OVR_EN
    checks++;
    if (ovr !== 1'b0) begin
      errors++; $display("FAIL fs_first_ovr: got %b expected 0", ovr);
    end
`endif
    for (int s = 2; s <= 6; s++) begin
      wait_strobe(20, n);
      checks++;
      if (n !== 4) begin
        errors++; $display("FAIL fs_spacing%0d: got %0d cycles expected 4", s, n);
      end
      checks++;
      if (data_out !== 7'd64) begin
        errors++; $display("FAIL fs_value%0d: got %0d expected 64", s, data_out);
      end
`ifdef SINC3_OVR_EN
      checks++;
      if (ovr !== 1'b1) begin
        errors++; $display("FAIL fs_ovr%0d: got %b expected 1", s, ovr);
      end
`endif
    end
    tick();
    checks++;
    if (data_valid !== 1'b0 || data_out !== 7'd64) begin
      errors++; $display("FAIL fs_hold: got valid=%b data_out=%0d expected valid=0 data_out=64",
                         data_valid, data_out);
    end
  endtask

  task automatic test_zero();
    int n;
    en_mode = 0; md_mode = 0;
    do_reset();
    for (int s = 1; s <= 3; s++) begin
      wait_strobe(40, n);
      checks++;
      if (n !== ((s == 1) ? 13 : 4)) begin
        errors++; $display("FAIL zero_spacing%0d: got %0d cycles", s, n);
      end
      checks++;
      if (data_out !== 7'd0) begin
        errors++; $display("FAIL zero_value%0d: got %0d expected 0", s, data_out);
      end
    end
  endtask

  task automatic test_alternate();
    int n;
    en_mode = 0; md_mode = 2;
    do_reset();
    for (int s = 1; s <= 5; s++) begin
      wait_strobe(40, n);
      checks++;
      if (n !== ((s == 1) ? 13 : 4)) begin
        errors++; $display("FAIL alt_spacing%0d: got %0d cycles", s, n);
      end
      if (s >= 3) begin
        checks++;
        if (data_out !== 7'd32) begin
          errors++; $display("FAIL alt_value%0d: got %0d expected 32", s, data_out);
        end
      end
    end
  endtask

  task automatic test_en_toggle();
    int n;
    en_mode = 1; md_mode = 1;
    do_reset();
    // First strobe's comb edge falls on an en=0 cycle.
    wait_strobe(60, n);
    checks++;
    if (n !== 24) begin
      errors++; $display("FAIL en_first_latency: got %0d cycles expected 24", n);
    end
    checks++;
    if (data_out !== 7'd63) begin
      errors++; $display("FAIL en_first_value: got %0d expected 63", data_out);
    end
    for (int s = 2; s <= 4; s++) begin
      wait_strobe(40, n);
      checks++;
      if (n !== 8) begin
        errors++; $display("FAIL en_spacing%0d: got %0d cycles expected 8", s, n);
      end
      checks++;
      if (data_out !== 7'd64) begin
        errors++; $display("FAIL en_value%0d: got %0d expected 64", s, data_out);
      end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    en_mode = 0; md_mode = 1;
    // Reset while data_out is non-zero from the previous test.
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 7'd0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL abort_clear: got data_out=%0d valid=%b expected 0 0", data_out, data_valid);
    end
    do_reset();
    // Ten enabled edges leave the counter at 2 inside the third period.
    wait_strobe(10, n);
    checks++;
    if (n !== -1) begin
      errors++; $display("FAIL abort_early_strobe: got strobe at %0d expected none", n);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (data_valid !== 1'b0 || data_out !== 7'd0) begin
        errors++; $display("FAIL abort_mid_hold%0d: got valid=%b data_out=%0d", k, data_valid, data_out);
      end
    end
    rst = 1'b0;
    wait_strobe(12, n);
    checks++;
    if (n !== -1) begin
      errors++; $display("FAIL abort_resettle: got strobe at %0d expected none", n);
    end
    // Comb step now pending: reset between E and E+1 must drop it.
    rst = 1'b1;
    tick();
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL abort_at_e: got valid=%b expected 0", data_valid);
    end
    rst = 1'b0;
    wait_strobe(40, n);
    checks++;
    if (n !== 13) begin
      errors++; $display("FAIL abort_first_latency: got %0d cycles expected 13", n);
    end
    checks++;
    if (data_out !== 7'd63) begin
      errors++; $display("FAIL abort_first_value: got %0d expected 63", data_out);
    end
  endtask

  task automatic test_osr256();
    int n;
    bit seen_low;
    @(negedge clk);
    rst_b = 1'b1; mdat_b = 1'b1; en_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    wait_strobe_b(1000, n);
    checks++;
    if (n !== 769) begin
      errors++; $display("FAIL big_first_latency: got %0d cycles expected 769", n);
    end
    for (int s = 2; s <= 4; s++) begin
      wait_strobe_b(300, n);
      checks++;
      if (n !== 256) begin
        errors++; $display("FAIL big_spacing%0d: got %0d cycles expected 256", s, n);
      end
      if (s >= 3) begin
        checks++;
        if (data_out_b !== FULL_B) begin
          errors++; $display("FAIL big_value%0d: got %0d expected 16777216", s, data_out_b);
        end
`ifdef SINC3_OVR_EN
        checks++;
        if (ovr_b !== 1'b1) begin
          errors++; $display("FAIL big_ovr%0d: got %b expected 1", s, ovr_b);
        end
`endif
      end
    end
    mdat_b = 1'b0;
    seen_low = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      wait_strobe_b(300, n);
      checks++;
      if (n !== 256) begin
        errors++; $display("FAIL big_zero_spacing%0d: got %0d cycles expected 256", s, n);
      end
      if (data_out_b < FULL_B) begin
        seen_low = 1'b1;
`ifdef SINC3_OVR_EN
        checks++;
        if (ovr_b !== 1'b0) begin
          errors++; $display("FAIL big_ovr_low%0d: got %b expected 0", s, ovr_b);
        end
`endif
      end
    end
    checks++;
    if (seen_low !== 1'b1 || data_out_b !== 25'd0) begin
      errors++; $display("FAIL big_decay: got data_out=%0d expected 0", data_out_b);
    end
  endtask

  initial begin
    rst = 1'b1; mdat = 1'b0; en = 1'b0;
    rst_b = 1'b1; mdat_b = 1'b0; en_b = 1'b0;
    test_reset();
    test_full_scale();
    test_zero();
    test_alternate();
    test_en_toggle();
    test_reset_abort();
    test_osr256();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
